// File: rtl/ln_unit.sv
// ln_unit: iterative Q2.6 -> Q1.6 natural log via leading-one normalise, mantissa squaring and ln2 scale.
module ln_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);
  typedef enum logic [2:0] {IDLE, NORM, ITER, SCALE, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] x_q, x_d, m_q, m_d, od_q, od_d;
  logic signed [3:0] e_q, e_d;
  logic [5:0] frac_q, frac_d;
  logic [2:0] cnt_q, cnt_d, p;
  logic zero_q, zero_d, ov_q, ov_d;
  logic [8:0] sq_hi;
  logic signed [9:0] l;
  logic signed [17:0] s;
  logic [7:0] sat;
  always_comb begin
    p = 3'd0;
    for (int i = 0; i < 8; i++) if (x_q[i]) p = 3'(i);
  end
  // top nine bits of the Q2.14 square cover both renormalisation choices
  assign sq_hi = 9'((16'(m_q) * 16'(m_q)) >> 7);
  assign l = {e_q, frac_q};
  assign s = (18'(l) * 18'sd177) >>> 8;
  assign sat = s > 18'sd127 ? 8'd127 : s < -18'sd128 ? 8'h80 : s[7:0];
  assign in_ready = state_q == IDLE;
  assign out_valid = ov_q;
  assign out_data = od_q;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    m_d = m_q;
    e_d = e_q;
    frac_d = frac_q;
    cnt_d = cnt_q;
    zero_d = zero_q;
    od_d = od_q;
    ov_d = ov_q;
    case (state_q)
      IDLE: if (in_valid) begin
        x_d = in_data;
        state_d = NORM;
      end
      NORM: begin
        zero_d = x_q == 8'd0;
        e_d = $signed({1'b0, p}) - 4'sd6;
        m_d = x_q << (3'd7 - p);
        frac_d = 6'd0;
        cnt_d = 3'd0;
        state_d = ITER;
      end
      ITER: begin
        frac_d = {frac_q[4:0], sq_hi[8]};
        m_d = sq_hi[8] ? sq_hi[8:1] : sq_hi[7:0];
        cnt_d = cnt_q + 3'd1;
        state_d = cnt_q == 3'd5 ? SCALE : ITER;
      end
      SCALE: begin
        od_d = zero_q ? 8'h80 : sat;
        ov_d = 1'b1;
        state_d = DONE;
      end
      DONE: if (out_ready) begin
        ov_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      m_q <= '0;
      e_q <= '0;
      frac_q <= '0;
      cnt_q <= '0;
      zero_q <= 1'b0;
      od_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      m_q <= m_d;
      e_q <= e_d;
      frac_q <= frac_d;
      cnt_q <= cnt_d;
      zero_q <= zero_d;
      od_q <= od_d;
      ov_q <= ov_d;
    end
  end
endmodule

// File: tb/tb_ln_unit.sv
// tb_ln_unit: scoreboard bench for ln_unit with a behavioural log2/ln reference.
module tb_ln_unit;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [7:0] in_data = 0, out_data;
  int checks = 0, failures = 0, cyc = 0;
  int exp_q[$], xs_q[$], lat_q[$];
  bit ov_prev = 0, sweep_done = 0;

  ln_unit dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
               .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string nm, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // log2 by repeated squaring of the normalised mantissa, then ln = log2 * 177/256 with floor
  function automatic int model(input int x);
    int p, m, fr, l, s, sq;
    if (x == 0) return -128;
    p = 0;
    for (int k = 0; k < 8; k++) if (x >= (1 << k)) p = k;
    m = x * (1 << (7 - p));
    fr = 0;
    for (int k = 0; k < 6; k++) begin
      sq = m * m;
      if (sq >= 32768) begin fr = fr * 2 + 1; m = sq / 256; end
      else begin fr = fr * 2; m = sq / 128; end
    end
    l = (p - 6) * 64 + fr;
    s = l * 177;
    s = s >= 0 ? s / 256 : -((-s + 255) / 256);
    return s > 127 ? 127 : s < -128 ? -128 : s;
  endfunction

  task automatic do_op(input int x, input int e);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk(0, "in_ready_timeout", 0, 1);
    in_valid = 1;
    in_data = 8'(x);
    @(posedge clk);
    #1;
    in_valid = 0;
    exp_q.push_back(e);
    xs_q.push_back(x);
    lat_q.push_back(cyc);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk(out_valid, "wait_out_valid", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    xs_q.delete();
    lat_q.delete();
  endtask

  always @(negedge clk) begin
    if (rst) ov_prev = 0;
    else begin
      if (out_valid && !ov_prev) begin
        if (lat_q.size() == 0) chk(0, "spurious_valid", 1, 0);
        else begin
          int a;
          a = lat_q.pop_front();
          chk(cyc - a == 8, "latency", cyc - a, 8);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk(0, "spurious_output", $signed(out_data), 0);
        else begin
          int e, x, rr;
          real r;
          e = exp_q.pop_front();
          x = xs_q.pop_front();
          chk($signed(out_data) == e, "out_data", $signed(out_data), e);
          if (x > 0) begin
            r = 64.0 * $ln(x / 64.0);
            rr = int'(r);
            if (rr >= -128 && rr <= 127)
              chk(($signed(out_data) - rr) <= 2 && (rr - $signed(out_data)) <= 2, "ln_accuracy", $signed(out_data), rr);
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    #12;
    chk(in_ready == 1, "reset_in_ready", in_ready, 1);
    chk(out_valid == 0, "reset_out_valid", out_valid, 0);
    chk(out_data == 0, "reset_out_data", out_data, 0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    out_ready = 1;
    do_op(64, 0);
    do_op(128, 44);
    do_op(32, -45);
    do_op(255, 87);
    do_op(1, -128);
    do_op(0, -128);
    drain();

    out_ready = 0;
    do_op(128, 44);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk(out_valid == 1, "bp_out_valid", out_valid, 1);
      chk($signed(out_data) == 44, "bp_out_data", $signed(out_data), 44);
      chk(in_ready == 0, "bp_in_ready", in_ready, 0);
      in_valid = i == 2;
      in_data = 8'd200;
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk(in_ready == 1, "bp_release_in_ready", in_ready, 1);
    chk(out_valid == 0, "bp_release_out_valid", out_valid, 0);
    chk(exp_q.size() == 0, "bp_consumed", exp_q.size(), 0);

    out_ready = 0;
    do_op(64, 0);
    wait_valid();
    @(negedge clk); #2;
    rst = 1;
    clear_sb();
    #1;
    chk(in_ready == 1, "async_in_ready", in_ready, 1);
    chk(out_valid == 0, "async_out_valid", out_valid, 0);
    chk(out_data == 0, "async_out_data", out_data, 0);
    @(negedge clk) rst = 0;
    out_ready = 1;

    @(posedge clk); #1;
    do_op(255, 87);
    repeat (3) @(posedge clk);
    #2;
    rst = 1;
    clear_sb();
    @(posedge clk); #2;
    rst = 0;
    @(posedge clk); #1;
    chk(in_ready == 1, "midop_in_ready", in_ready, 1);
    repeat (12) @(posedge clk);
    #1;
    chk(out_valid == 0, "midop_no_output", out_valid, 0);
    do_op(64, 0);
    drain();

    fork
      begin
        for (int x = 0; x < 256; x++) do_op(x, model(x));
        sweep_done = 1;
      end
      begin
        while (!sweep_done) begin
          out_ready = $urandom_range(0, 3) != 0;
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ln_unit.md
# ln_unit

Iterative fixed-point natural-logarithm unit: the inverse of the attention engine's exp stage, mapping a positive unsigned Q2.6 operand to a saturated signed Q1.6 result. It sits after the exp/normalisation path wherever log-domain scores are needed (log-softmax, log-sum-exp re-centring). The datapath is a leading-one normaliser followed by six mantissa-squaring iterations, producing log2, then a ln2 scale. Valid/ready handshakes on both sides; one operation in flight at a time.

## Interface

- No parameters; widths and formats are fixed.

- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  unit idle, can accept.
- in_data  input  8  unsigned Q2.6 operand, 0..255 = 0..3.984.
- out_valid  output  1  result valid, held until accepted.
- out_ready  input  1  consumer accepts result.
- out_data  output  8  signed Q1.6 ln(in_data), saturated to [-128, 127].

## Operation

- States: IDLE, NORM, ITER, SCALE, DONE.
- in_ready = (state == IDLE). Accept edge is in_valid & in_ready: latch x = in_data, go to NORM.
- NORM: if x == 0, set a zero flag. Otherwise find the leading-one position p (0..7). Set e = p - 6 (signed) and m = x << (7 - p), an 8-bit Q1.7 value with MSB = 1. Clear frac and the iteration counter, then go to ITER.
- ITER, exactly 6 cycles: compute P = m * m (16-bit Q2.14).
  - If P[15] = 1: shift a 1 into frac LSB and set m = P[15:8].
  - Else: shift in 0 and set m = P[14:7].
  - Truncation only. After the 6th iteration go to SCALE.
- SCALE:
  - L = e * 64 + frac is 10-bit signed Q3.6 log2, range -384..127.
  - S = (L * 177) >>> 8 uses an 18-bit signed product and arithmetic shift, i.e. floor.
  - out_data = clamp(S, -128, 127). The zero flag forces -128.
  - Set out_valid = 1 and go to DONE.
- DONE: out_data and out_valid are held stable while out_ready is low. On the edge where out_valid & out_ready, clear out_valid and go to IDLE.
- in_valid is ignored in every state except IDLE. in_data is sampled only on the accept edge.
- The zero operand takes the same path and latency as any other operand (fixed latency).

## Timing

- Reset, asynchronous and effective immediately:
  - state = IDLE, so in_ready = 1.
  - out_valid = 0, out_data = 0.
  - Internal x, m, e, frac, counter and zero flag = 0.
- Reset mid-operation, in any state, aborts the operation with no output produced. in_ready is 1 in the first cycle after rst deasserts.
- Latency: the accept edge is edge 0. NORM is edge 1, ITER is edges 2..7, SCALE is edge 8. out_valid is high after edge 8 regardless of operand value.
- If out_ready is already high when out_valid rises, the result is consumed on edge 9 and in_ready is high after edge 9. The next accept is possible on edge 10, giving a throughput of 1 op per 10 cycles.
- There is no same-cycle output release and input accept: in_ready is low throughout DONE.
- All outputs are registered or decoded from the state register only; no combinational path from in_valid or out_ready to any output.

## Test plan

- Reset and idle: assert rst asynchronously between edges. Required: in_ready=1, out_valid=0 and out_data=0 immediately, with no clock edge needed.
- Exact points, out_ready held high:
  - in_data=64 (1.0) -> out_data=0.
  - in_data=128 (2.0) -> 44.
  - in_data=32 (0.5) -> -45 (0xD3).
  - Each must appear with out_valid rising exactly 8 edges after the accept edge.
- Extremes:
  - in_data=255 -> frac=63, L=127, out_data=87.
  - in_data=1 -> L=-384, S=-266, saturated to -128.
  - in_data=0 -> -128 with identical latency.
- Backpressure: accept 128, then hold out_ready low for 5 cycles. Required: out_data=44 and out_valid=1 are stable throughout, in_ready=0, and an in_valid pulse offered meanwhile is ignored. Raise out_ready: one handshake, then in_ready=1 on the next cycle.
- Reset mid-op: accept 255, then assert rst during ITER (edge 4). Required: out_valid never rises, and a fresh 64 accepted after reset yields 0 at normal latency.
- Sweep: all 256 in_data values back-to-back with random out_ready stalls. Required:
  - Outputs match a bit-exact reference model of the NORM/ITER/SCALE arithmetic.
  - Outputs are within 2 LSB of round(64 * ln(x/64)) wherever that value is unsaturated.
